// File: rtl/add_arb_pkg.sv
// -----------------------------------------------------------------------------
// add_arb_pkg
// Shared definitions for the shared-adder arbiter:
//   DATA_W        operand / result width of the shared adder
//   NREQ_DEFAULT  default number of requesters sharing the adder
//   add_arb_state_e  response-holding FSM state (IDLE, HOLD)
// -----------------------------------------------------------------------------
package add_arb_pkg;

    localparam int DATA_W       = 32;
    localparam int NREQ_DEFAULT = 4;

    // IDLE: no result held. HOLD: result held, resp_valid is high.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } add_arb_state_e;

    // Signed overflow of a two's-complement add, from operand and result MSBs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/carry_select_adder_signed_32bit.sv
// -----------------------------------------------------------------------------
// carry_select_adder_signed_32bit
// 32-bit carry-select adder. Each 8-bit block precomputes its sum for a
// carry-in of 0 and of 1; the real carry from the block below picks one.
// Ports:
//   a_i, b_i     32-bit operands
//   cin_i        carry into bit 0
//   sum_o        32-bit sum (modulo 2^32)
//   cout_o       carry out of bit 31
//   zero_flag_o  high when sum_o is zero (carry-out is not considered)
// -----------------------------------------------------------------------------
module carry_select_adder_signed_32bit
    import add_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o,
    output logic              zero_flag_o
);

    localparam int BLK_W = 8;
    localparam int NBLK  = DATA_W / BLK_W;

    // carry[k] is the carry into block k; carry[NBLK] is the final carry-out.
    logic [NBLK:0] carry;

    assign carry[0] = cin_i;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic [BLK_W:0] sum_c0;
        logic [BLK_W:0] sum_c1;

        assign sum_c0 = {1'b0, a_i[k*BLK_W +: BLK_W]} + {1'b0, b_i[k*BLK_W +: BLK_W]};
        assign sum_c1 = {1'b0, a_i[k*BLK_W +: BLK_W]} + {1'b0, b_i[k*BLK_W +: BLK_W]}
                        + {{BLK_W{1'b0}}, 1'b1};

        assign sum_o[k*BLK_W +: BLK_W] = carry[k] ? sum_c1[BLK_W-1:0] : sum_c0[BLK_W-1:0];
        assign carry[k+1]              = carry[k] ? sum_c1[BLK_W]     : sum_c0[BLK_W];
    end

    assign cout_o      = carry[NBLK];
    assign zero_flag_o = ~|sum_o;

endmodule

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin picker. The search starts at last_grant_i+1 (mod NREQ) and
// returns the first set request bit.
// Ports:
//   req_i         request vector, one bit per requester
//   last_grant_i  index granted most recently
//   grant_o       one-hot grant (all-zero when no request is set)
//   idx_o         index of the granted requester (0 when none)
//   any_o         high when some request is set
// -----------------------------------------------------------------------------
module rr_pick
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int            cand;
    logic [IDW-1:0] cand_idx;
    logic          found;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // k runs 1..NREQ so the previously granted requester is looked at last.
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_grant_i) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/add_share_arbiter.sv
// -----------------------------------------------------------------------------
// add_share_arbiter
// NREQ requesters share one 32-bit adder. A round-robin picker selects one
// requester per accept; its operands go through the shared adder and the
// result is registered into a one-entry response slot.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge. req_ready is a combinational function of
// state, resp_ready and req_valid (at most one bit set); resp_valid and all
// resp_* fields are registered and stay stable until resp_ready is seen.
//
// Optional feature: define ADD_ARB_OVF_EN to add the resp_ovf output
// (registered signed overflow of the granted operands).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake
//   req_a, req_b        packed operands, requester i at [32*i+31:32*i]
//   req_cin             per-requester carry-in
//   resp_valid/ready    response handshake
//   resp_id             owner of the held result
//   resp_sum/cout/zero  result, carry-out of bit 31, sum==0 flag
//   resp_ovf            signed overflow (ADD_ARB_OVF_EN only)
//   dbg_state_o         current FSM state
//   dbg_last_grant_o    most recently granted requester
// -----------------------------------------------------------------------------
module add_share_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [DATA_W-1:0]      resp_sum,
    output logic                   resp_cout,
    output logic                   resp_zero,
`ifdef ADD_ARB_OVF_EN
    output logic                   resp_ovf,
`endif
    output add_arb_state_e         dbg_state_o,
    output logic [IDW-1:0]         dbg_last_grant_o
);

    // ------------------------------------------------------------------
    // Registered state and response
    // ------------------------------------------------------------------
    add_arb_state_e    state_q;
    logic              resp_valid_q;
    logic [IDW-1:0]    resp_id_q;
    logic [DATA_W-1:0] resp_sum_q;
    logic              resp_cout_q;
    logic              resp_zero_q;
    logic [IDW-1:0]    last_grant_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] rr_grant;
    logic [IDW-1:0]  rr_idx;
    logic            rr_any;
    logic            can_accept;
    logic            accept;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .idx_o        (rr_idx),
        .any_o        (rr_any)
    );

    // The slot is free when empty, or when its current result leaves this
    // cycle; that second case gives back-to-back results with no bubble.
    assign can_accept = !rst && ((state_q == IDLE) || resp_ready);
    assign accept     = can_accept && rr_any;
    assign req_ready  = accept ? rr_grant : '0;

    // ------------------------------------------------------------------
    // Shared adder on the granted requester's operands
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              cin_sel;
    logic [DATA_W-1:0] sum_d;
    logic              cout_d;
    logic              zero_d;

    assign a_sel   = req_a[int'(rr_idx)*DATA_W +: DATA_W];
    assign b_sel   = req_b[int'(rr_idx)*DATA_W +: DATA_W];
    assign cin_sel = req_cin[rr_idx];

    carry_select_adder_signed_32bit u_adder (
        .a_i         (a_sel),
        .b_i         (b_sel),
        .cin_i       (cin_sel),
        .sum_o       (sum_d),
        .cout_o      (cout_d),
        .zero_flag_o (zero_d)
    );

`ifdef ADD_ARB_OVF_EN
    logic resp_ovf_q;
    logic ovf_d;

    assign ovf_d = signed_ovf(a_sel[DATA_W-1], b_sel[DATA_W-1], sum_d[DATA_W-1]);
`endif

    // ------------------------------------------------------------------
    // FSM and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_zero_q  <= 1'b0;
            // Highest index as "last" makes requester 0 first after reset.
            last_grant_q <= IDW'(NREQ - 1);
`ifdef ADD_ARB_OVF_EN
            resp_ovf_q   <= 1'b0;
`endif
        end else begin
            // A new result overwrites the slot whenever one is accepted,
            // whether the slot was empty or being emptied this cycle.
            if (accept) begin
                resp_id_q    <= rr_idx;
                resp_sum_q   <= sum_d;
                resp_cout_q  <= cout_d;
                resp_zero_q  <= zero_d;
                last_grant_q <= rr_idx;
`ifdef ADD_ARB_OVF_EN
                resp_ovf_q   <= ovf_d;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= HOLD;
                        resp_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // Stay in HOLD if the result is not consumed or a new one
                    // replaces it; drain to IDLE only when consumed with
                    // nothing waiting.
                    if (resp_ready && !accept) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_id          = resp_id_q;
    assign resp_sum         = resp_sum_q;
    assign resp_cout        = resp_cout_q;
    assign resp_zero        = resp_zero_q;
`ifdef ADD_ARB_OVF_EN
    assign resp_ovf         = resp_ovf_q;
`endif
    assign dbg_state_o      = state_q;
    assign dbg_last_grant_o = last_grant_q;

endmodule
